scrambler: RTL and testbench

//  Transmit-side counterpart of the macroblock sign unscrambler. Takes one 64-bit

---
 rtl/scrambler_pkg.sv | 29 ++
 rtl/scrambler_bitsel.sv | 22 ++
 rtl/scrambler.sv | 134 +++++++++++++
 tb/tb_scrambler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared definitions for the macroblock sign scrambler and the
// unscrambler-side test models: widths, position field layout, FSM states.
package scrambler_pkg;

    // Message word and scan-position geometry.
    localparam int WORD_W   = 64;
    localparam int POS_W    = $clog2(WORD_W);
    localparam int POSF_W   = POS_W + 1;
    localparam int POS_LAST = POS_W;

    // Bit counter / declared size width (0..WORD_W inclusive).
    localparam int SIZE_W = POS_W + 1;
    localparam logic [SIZE_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK
    } state_t;

    // Scan position 0 maps to the message MSB.
    function automatic logic [POS_W-1:0] bit_index(
        input logic [POS_W-1:0] pos
    );
        return POS_W'(WORD_W - 1) - pos;
    endfunction

endpackage

// File: rtl/scrambler_bitsel.sv
// Registered 64:1 bit select of the current message word, indexed by scan
// position. Ports: clk, rst (async active-low), en, word, pos -> bit_out.
module scrambler_bitsel
    import scrambler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    input  logic [POS_W-1:0]  pos,
    output logic              bit_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_out <= 1'b0;
        end else if (en) begin
            bit_out <= word[bit_index(pos)];
        end
    end

endmodule

// File: rtl/scrambler.sv
// Transmit-side sign scrambler: one message word per macroblock, one sign
// bit per popped scan position, emitted in position order with a size check.
// Ports:
//   clk, rst (async active-low), clk_en (global stall)
//   msg_in/msg_size/msg_empty/msg_rd : message FIFO (non-show-ahead)
//   pos_in/pos_empty/pos_rd          : position FIFO, pos_in[6] = last of mb
//   sign_afull                       : sign FIFO nearly full (2-entry margin)
//   sign_out/sign_last/sign_wr       : sign FIFO write side
//   size_err                         : emitted count != declared size
module scrambler
    import scrambler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [WORD_W-1:0] msg_in,
    input  logic [SIZE_W-1:0] msg_size,
    input  logic              msg_empty,
    output logic              msg_rd,
    input  logic [POSF_W-1:0] pos_in,
    input  logic              pos_empty,
    output logic              pos_rd,
    input  logic              sign_afull,
    output logic              sign_out,
    output logic              sign_last,
    output logic              sign_wr,
    output logic              size_err
);

    state_t state;
    state_t state_nxt;

    logic [WORD_W-1:0] word_r;
    logic [SIZE_W-1:0] size_r;
    logic [SIZE_W-1:0] cnt;
    logic              pos_v;
    logic              end_seen;
    logic              sign_wr_q;
    logic              sign_last_q;

    logic run_v;
    logic last_v;
    logic stop;

    // A valid position is only consumed in RUN; last_v closes the mb.
    assign run_v  = pos_v && (state == RUN);
    assign last_v = run_v && pos_in[POS_LAST];

    // Never fetch past the last position of the current mb.
    assign stop = (pos_v && pos_in[POS_LAST]) || end_seen;

    always_comb begin
        state_nxt = state;
        msg_rd    = 1'b0;
        pos_rd    = 1'b0;
        size_err  = 1'b0;
        unique case (state)
            IDLE: begin
                msg_rd = clk_en && !msg_empty;
                if (msg_rd) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (clk_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                pos_rd = clk_en && !pos_empty && !sign_afull && !stop;
                if (clk_en && last_v) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                // cnt already includes the last bit of the mb here.
                size_err = clk_en && (cnt != size_r);
                if (clk_en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            word_r      <= '0;
            size_r      <= '0;
            cnt         <= '0;
            pos_v       <= 1'b0;
            end_seen    <= 1'b0;
            sign_wr_q   <= 1'b0;
            sign_last_q <= 1'b0;
        end else if (clk_en) begin
            state     <= state_nxt;
            pos_v     <= pos_rd;
            sign_wr_q <= run_v;
            if (run_v) begin
                sign_last_q <= pos_in[POS_LAST];
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (last_v) begin
                end_seen <= 1'b1;
            end
            if (state == LOAD) begin
                word_r   <= msg_in;
                size_r   <= msg_size;
                cnt      <= '0;
                end_seen <= 1'b0;
            end
        end
    end

    // Bit select is registered alongside sign_wr_q so data and strobe align.
    scrambler_bitsel u_bitsel (
        .clk     (clk),
        .rst     (rst),
        .en      (clk_en && run_v),
        .word    (word_r),
        .pos     (pos_in[POS_W-1:0]),
        .bit_out (sign_out)
    );

    // A held write is replayed exactly once when the stall lifts.
    assign sign_wr   = sign_wr_q && clk_en;
    assign sign_last = sign_last_q;

endmodule

// File: tb/tb_scrambler.sv
// Self-checking bench for scrambler: FIFO models, scoreboard of expected
// sign bits, latency and strobe checks, directed scenarios.
module tb_scrambler;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [63:0] msg_in;
    logic [6:0]  msg_size;
    logic        msg_empty;
    logic        msg_rd;
    logic [6:0]  pos_in;
    logic        pos_empty;
    logic        pos_rd;
    logic        sign_afull;
    logic        sign_out;
    logic        sign_last;
    logic        sign_wr;
    logic        size_err;

    scrambler dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .msg_in     (msg_in),
        .msg_size   (msg_size),
        .msg_empty  (msg_empty),
        .msg_rd     (msg_rd),
        .pos_in     (pos_in),
        .pos_empty  (pos_empty),
        .pos_rd     (pos_rd),
        .sign_afull (sign_afull),
        .sign_out   (sign_out),
        .sign_last  (sign_last),
        .sign_wr    (sign_wr),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    logic [70:0] msg_q[$];
    logic [6:0]  pos_q[$];
    logic [1:0]  exp_q[$];
    int          rd_t[$];
    int          wr_t[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt = 0;
    int err_pulses = 0;

    // One clock: observe at negedge, then model FIFO pops after posedge.
    task automatic step();
        logic mpop;
        logic ppop;
        logic [1:0] e;
        int t;
        @(negedge clk);
        mpop = msg_rd;
        ppop = pos_rd;
        if (!clk_en) begin
            n_cmp++;
            if ({sign_wr, size_err, msg_rd, pos_rd} !== 4'b0000) begin
                n_bad++;
                $display("FAIL stall_strobes got %b want 0000",
                         {sign_wr, size_err, msg_rd, pos_rd});
            end
        end else begin
            ecnt++;
            if (pos_rd) rd_t.push_back(ecnt);
            if (size_err) err_pulses++;
            if (sign_afull) begin
                n_cmp++;
                if (pos_rd !== 1'b0) begin
                    n_bad++;
                    $display("FAIL afull_pos_rd got %b want 0", pos_rd);
                end
            end
            if (sign_wr) begin
                wr_t.push_back(ecnt);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sign_unexpected got %b want none",
                             {sign_last, sign_out});
                end else begin
                    e = exp_q.pop_front();
                    if ({sign_last, sign_out} !== e) begin
                        n_bad++;
                        $display("FAIL sign_bit got last,bit=%b want %b",
                                 {sign_last, sign_out}, e);
                    end
                end
                n_cmp++;
                if (rd_t.size() == 0) begin
                    n_bad++;
                    $display("FAIL latency got write without pos_rd want rd");
                end else begin
                    t = rd_t.pop_front();
                    if (ecnt - t !== 2) begin
                        n_bad++;
                        $display("FAIL latency got %0d want 2", ecnt - t);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (mpop && msg_q.size() != 0) {msg_size, msg_in} = msg_q.pop_front();
        if (ppop && pos_q.size() != 0) pos_in = pos_q.pop_front();
        msg_empty = (msg_q.size() == 0);
        pos_empty = (pos_q.size() == 0);
    endtask

    task automatic send_mb(input logic [63:0] word, input logic [6:0] size,
                           input int n, input logic [6:0] ps [16]);
        int idx;
        msg_q.push_back({size, word});
        for (int i = 0; i < n; i++) begin
            pos_q.push_back(ps[i]);
            idx = 63 - int'(ps[i][5:0]);
            exp_q.push_back({ps[i][6], word[idx]});
        end
        msg_empty = 1'b0;
        pos_empty = (pos_q.size() == 0);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 300;
        while ((exp_q.size() != 0 || pos_q.size() != 0 || msg_q.size() != 0)
               && budget > 0) begin
            step();
            budget--;
        end
        repeat (3) step();
        n_cmp++;
        if (exp_q.size() != 0 || pos_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain got %0d bits pending want 0",
                     name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clk_en = 1'b1;
        msg_in = '0;
        msg_size = '0;
        msg_empty = 1'b1;
        pos_in = '0;
        pos_empty = 1'b1;
        sign_afull = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({sign_out, sign_last, sign_wr, size_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outs got %b want 0000",
                     {sign_out, sign_last, sign_wr, size_err});
        end
        n_cmp++;
        if ({msg_rd, pos_rd} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_rd got %b want 00", {msg_rd, pos_rd});
        end
        rst = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        logic [6:0] p [16];
        int e0;
        p = '{default: 7'd0};
        p[0] = 7'd0;
        p[1] = 7'h40 | 7'd63;
        e0 = err_pulses;
        send_mb(64'h8000_0000_0000_0001, 7'd2, 2, p);
        drain("basic");
        n_cmp++;
        if (err_pulses - e0 !== 0) begin
            n_bad++;
            $display("FAIL basic_size_err got %0d want 0", err_pulses - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] p [16];
        int e0;
        p = '{default: 7'd0};
        p[0] = 7'd3;
        p[1] = 7'd2;
        p[2] = 7'd1;
        p[3] = 7'h40;
        e0 = err_pulses;
        wr_t.delete();
        send_mb(64'hF000_0000_0000_0000, 7'd4, 4, p);
        drain("b2b");
        n_cmp++;
        if (wr_t.size() !== 4) begin
            n_bad++;
            $display("FAIL b2b_count got %0d want 4", wr_t.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (wr_t[i] - wr_t[i-1] !== 1) begin
                    n_bad++;
                    $display("FAIL b2b_gap got %0d want 1",
                             wr_t[i] - wr_t[i-1]);
                end
            end
        end
        n_cmp++;
        if (err_pulses - e0 !== 0) begin
            n_bad++;
            $display("FAIL b2b_size_err got %0d want 0", err_pulses - e0);
        end
    endtask

    task automatic test_size_err();
        logic [6:0] p [16];
        int e0;
        p = '{default: 7'd0};
        p[0] = 7'd10;
        p[1] = 7'd20;
        p[2] = 7'h40 | 7'd30;
        e0 = err_pulses;
        wr_t.delete();
        send_mb({$urandom, $urandom}, 7'd5, 3, p);
        drain("sizeerr");
        n_cmp++;
        if (wr_t.size() !== 3) begin
            n_bad++;
            $display("FAIL sizeerr_count got %0d want 3", wr_t.size());
        end
        n_cmp++;
        if (err_pulses - e0 !== 1) begin
            n_bad++;
            $display("FAIL sizeerr_pulse got %0d want 1", err_pulses - e0);
        end
        // Duplicate position and empty declared size: one bit, one error.
        p[0] = 7'h40 | 7'd7;
        e0 = err_pulses;
        send_mb({$urandom, $urandom}, 7'd0, 1, p);
        drain("size0");
        n_cmp++;
        if (err_pulses - e0 !== 1) begin
            n_bad++;
            $display("FAIL size0_pulse got %0d want 1", err_pulses - e0);
        end
        p[0] = 7'd5;
        p[1] = 7'd5;
        p[2] = 7'h40 | 7'd62;
        e0 = err_pulses;
        send_mb({$urandom, $urandom}, 7'd3, 3, p);
        drain("dup");
        n_cmp++;
        if (err_pulses - e0 !== 0) begin
            n_bad++;
            $display("FAIL dup_size_err got %0d want 0", err_pulses - e0);
        end
    endtask

    task automatic test_afull();
        logic [6:0] p [16];
        int e0;
        int base;
        p = '{default: 7'd0};
        for (int i = 0; i < 12; i++) p[i] = 7'($urandom_range(0, 63));
        p[11] = p[11] | 7'h40;
        e0 = err_pulses;
        wr_t.delete();
        send_mb({$urandom, $urandom}, 7'd12, 12, p);
        repeat (7) step();
        sign_afull = 1'b1;
        step();
        base = wr_t.size();
        repeat (9) step();
        n_cmp++;
        if (wr_t.size() - base > 1) begin
            n_bad++;
            $display("FAIL afull_extra got %0d want <=1", wr_t.size() - base);
        end
        sign_afull = 1'b0;
        drain("afull");
        n_cmp++;
        if (wr_t.size() !== 12) begin
            n_bad++;
            $display("FAIL afull_count got %0d want 12", wr_t.size());
        end
        n_cmp++;
        if (err_pulses - e0 !== 0) begin
            n_bad++;
            $display("FAIL afull_size_err got %0d want 0", err_pulses - e0);
        end
    endtask

    task automatic test_stall();
        logic [6:0] p [16];
        int e0;
        p = '{default: 7'd0};
        for (int i = 0; i < 10; i++) p[i] = 7'($urandom_range(0, 63));
        p[9] = p[9] | 7'h40;
        e0 = err_pulses;
        wr_t.delete();
        send_mb({$urandom, $urandom}, 7'd10, 10, p);
        repeat (6) step();
        clk_en = 1'b0;
        repeat (5) step();
        clk_en = 1'b1;
        drain("stall");
        n_cmp++;
        if (wr_t.size() !== 10) begin
            n_bad++;
            $display("FAIL stall_count got %0d want 10", wr_t.size());
        end
        n_cmp++;
        if (err_pulses - e0 !== 0) begin
            n_bad++;
            $display("FAIL stall_size_err got %0d want 0", err_pulses - e0);
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] p [16];
        int e0;
        p = '{default: 7'd0};
        for (int i = 0; i < 12; i++) p[i] = 7'(i * 3);
        p[11] = p[11] | 7'h40;
        send_mb(64'hFFFF_FFFF_FFFF_FFFF, 7'd12, 12, p);
        repeat (7) step();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({sign_out, sign_last, sign_wr, size_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_outs got %b want 0000",
                     {sign_out, sign_last, sign_wr, size_err});
        end
        n_cmp++;
        if (pos_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_pos_rd got %b want 0", pos_rd);
        end
        // Upstream FIFOs are flushed together with the scrambler.
        msg_q.delete();
        pos_q.delete();
        exp_q.delete();
        rd_t.delete();
        msg_empty = 1'b1;
        pos_empty = 1'b1;
        pos_in = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 5; i++) p[i] = 7'(60 - i * 7);
        p[4] = p[4] | 7'h40;
        e0 = err_pulses;
        wr_t.delete();
        send_mb(64'hA5C3_0F96_1234_8001, 7'd5, 5, p);
        drain("midrst");
        n_cmp++;
        if (wr_t.size() !== 5) begin
            n_bad++;
            $display("FAIL midrst_count got %0d want 5", wr_t.size());
        end
        n_cmp++;
        if (err_pulses - e0 !== 0) begin
            n_bad++;
            $display("FAIL midrst_size_err got %0d want 0", err_pulses - e0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_size_err();
        test_afull();
        test_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
